// File: rtl/tlb_pkg.sv
// Shared types and constants for the translation cache in front of the page-table walker.
// Provides:
//   tlb_state_e  - fill-controller FSM states
//   tlb_entry_t  - one cache entry {valid, vpn, ppn}
//   vpn_of()     - virtual page number of a 64b virtual address (4 KiB pages)
package tlb_pkg;

   localparam int unsigned BUS_DATA_WIDTH = 64;
   localparam int unsigned VPN_WIDTH      = 36;
   localparam int unsigned PPN_WIDTH      = 44;
   localparam int unsigned PAGE_SHIFT     = 12;
   localparam int unsigned PPN_LSB        = 10;
   localparam int unsigned PTE_V          = 0;

   typedef enum logic [2:0] {
      StIdle,
      StLookup,
      StWalkStart,
      StWalkDrop,
      StWalkWait,
      StFill,
      StResp
   } tlb_state_e;

   typedef struct packed {
      logic                 valid;
      logic [VPN_WIDTH-1:0] vpn;
      logic [PPN_WIDTH-1:0] ppn;
   } tlb_entry_t;

   function automatic logic [VPN_WIDTH-1:0] vpn_of(input logic [BUS_DATA_WIDTH-1:0] va);
      return va[PAGE_SHIFT +: VPN_WIDTH];
   endfunction

endpackage

// File: rtl/tlb_cam.sv
// Fully-associative entry store with parallel VPN compare.
// Ports:
//   clk, reset            - clock, synchronous active-high reset (clears valid bits)
//   clear                 - flash-clear all valid bits on the next edge
//   wr_en/wr_idx/wr_entry - single write port; clear has priority over a write
//   lookup_vpn            - VPN to compare against all valid entries (combinational)
//   hit/hit_idx/hit_ppn   - compare result; lowest matching index wins
module tlb_cam
   import tlb_pkg::*;
#(
   parameter int unsigned TLB_ENTRIES = 8,
   parameter int unsigned IdxW        = $clog2(TLB_ENTRIES)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 wr_en,
   input  logic [IdxW-1:0]      wr_idx,
   input  tlb_entry_t           wr_entry,
   input  logic [VPN_WIDTH-1:0] lookup_vpn,
   output logic                 hit,
   output logic [IdxW-1:0]      hit_idx,
   output logic [PPN_WIDTH-1:0] hit_ppn
);

   tlb_entry_t entries_q [TLB_ENTRIES];

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         for (int i = 0; i < TLB_ENTRIES; i++) begin
            entries_q[i].valid <= 1'b0;
         end
      end else if (wr_en) begin
         entries_q[wr_idx] <= wr_entry;
      end
   end

   // Scan from the top down so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      hit_ppn = '0;
      for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
         if (entries_q[i].valid && (entries_q[i].vpn == lookup_vpn)) begin
            hit     = 1'b1;
            hit_idx = IdxW'(i);
            hit_ppn = entries_q[i].ppn;
         end
      end
   end

endmodule

// File: rtl/tlb_fill_ctrl.sv
// Translation cache sitting directly in front of the page-table walker.
// A request is looked up in the CAM; a hit answers two cycles after the handshake, a miss
// pulses walk_enable, waits for the walker's leaf PTE, fills a round-robin victim entry and
// answers. One translation is outstanding at a time.
// Ports:
//   clk, reset                        - clock, synchronous active-high reset
//   req_valid/req_ready/req_vaddr     - request handshake (ready only while idle)
//   resp_valid/resp_ack               - response, held until acknowledged
//   resp_paddr/resp_fault             - physical address, or fault with paddr 0
//   flush                             - invalidate every entry
//   walk_enable/walk_vaddr            - walker start pulse and the address being walked
//   walk_ready/walk_pte               - walker done flag and leaf PTE
module tlb_fill_ctrl
   import tlb_pkg::*;
#(
   parameter int unsigned TLB_ENTRIES = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [BUS_DATA_WIDTH-1:0] req_vaddr,
   output logic                      resp_valid,
   input  logic                      resp_ack,
   output logic [BUS_DATA_WIDTH-1:0] resp_paddr,
   output logic                      resp_fault,
   input  logic                      flush,
   output logic                      walk_enable,
   output logic [BUS_DATA_WIDTH-1:0] walk_vaddr,
   input  logic                      walk_ready,
   input  logic [BUS_DATA_WIDTH-1:0] walk_pte
);

   localparam int unsigned IdxW = $clog2(TLB_ENTRIES);
   localparam int unsigned PadW = BUS_DATA_WIDTH - PPN_WIDTH - PAGE_SHIFT;

   tlb_state_e           state_q;
   logic [IdxW-1:0]      victim_q;
   logic                 flush_pend_q;
   logic                 pte_v_q;
   logic [PPN_WIDTH-1:0] pte_ppn_q;

   logic                 cam_hit;
   logic [IdxW-1:0]      cam_hit_idx;
   logic [PPN_WIDTH-1:0] cam_hit_ppn;
   logic                 cam_clear;
   logic                 cam_wr_en;
   tlb_entry_t           cam_wr_entry;
   logic                 unused_bits;

   // A flush seen mid-walk is deferred to FILL so the entry being walked is never kept.
   always_comb begin
      cam_clear = 1'b0;
      if (state_q == StFill) begin
         cam_clear = flush | flush_pend_q;
      end else if (state_q inside {StIdle, StLookup, StResp}) begin
         cam_clear = flush;
      end
   end

   assign cam_wr_en    = (state_q == StFill) && pte_v_q && !cam_clear;
   assign cam_wr_entry = '{valid: 1'b1, vpn: vpn_of(walk_vaddr), ppn: pte_ppn_q};
   assign unused_bits  = ^{walk_pte[BUS_DATA_WIDTH-1:PPN_LSB+PPN_WIDTH],
                           walk_pte[PPN_LSB-1:PTE_V+1], cam_hit_idx};

   tlb_cam #(
      .TLB_ENTRIES (TLB_ENTRIES),
      .IdxW        (IdxW)
   ) u_cam (
      .clk        (clk),
      .reset      (reset),
      .clear      (cam_clear),
      .wr_en      (cam_wr_en),
      .wr_idx     (victim_q),
      .wr_entry   (cam_wr_entry),
      .lookup_vpn (vpn_of(walk_vaddr)),
      .hit        (cam_hit),
      .hit_idx    (cam_hit_idx),
      .hit_ppn    (cam_hit_ppn)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         victim_q     <= '0;
         flush_pend_q <= 1'b0;
         pte_v_q      <= 1'b0;
         pte_ppn_q    <= '0;
         req_ready    <= 1'b1;
         resp_valid   <= 1'b0;
         resp_paddr   <= '0;
         resp_fault   <= 1'b0;
         walk_enable  <= 1'b0;
         walk_vaddr   <= '0;
      end else begin
         if (flush && (state_q inside {StWalkStart, StWalkDrop, StWalkWait})) begin
            flush_pend_q <= 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  walk_vaddr <= req_vaddr;
                  req_ready  <= 1'b0;
                  state_q    <= StLookup;
               end
            end
            StLookup: begin
               if (cam_hit) begin
                  resp_paddr <= {{PadW{1'b0}}, cam_hit_ppn, walk_vaddr[PAGE_SHIFT-1:0]};
                  resp_fault <= 1'b0;
                  resp_valid <= 1'b1;
                  state_q    <= StResp;
               end else begin
                  walk_enable <= 1'b1;
                  state_q     <= StWalkStart;
               end
            end
            StWalkStart: begin
               walk_enable <= 1'b0;
               state_q     <= StWalkDrop;
            end
            StWalkDrop: begin
               // Ready left over from the previous walk must not be mistaken for completion.
               if (!walk_ready) begin
                  state_q <= StWalkWait;
               end
            end
            StWalkWait: begin
               if (walk_ready) begin
                  pte_v_q   <= walk_pte[PTE_V];
                  pte_ppn_q <= walk_pte[PPN_LSB +: PPN_WIDTH];
                  state_q   <= StFill;
               end
            end
            StFill: begin
               if (pte_v_q) begin
                  resp_paddr <= {{PadW{1'b0}}, pte_ppn_q, walk_vaddr[PAGE_SHIFT-1:0]};
                  resp_fault <= 1'b0;
               end else begin
                  resp_paddr <= '0;
                  resp_fault <= 1'b1;
               end
               if (cam_wr_en) begin
                  victim_q <= victim_q + IdxW'(1);
               end
               flush_pend_q <= 1'b0;
               resp_valid   <= 1'b1;
               state_q      <= StResp;
            end
            StResp: begin
               if (resp_ack) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state_q    <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tlb_fill_ctrl.sv
// Directed bench for tlb_fill_ctrl with a behavioural page-table walker model.
module tb_tlb_fill_ctrl;
   import tlb_pkg::*;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_vaddr;
   logic        resp_valid;
   logic        resp_ack;
   logic [63:0] resp_paddr;
   logic        resp_fault;
   logic        flush;
   logic        walk_enable;
   logic [63:0] walk_vaddr;
   logic        walk_ready;
   logic [63:0] walk_pte;

   int vectors     = 0;
   int miscompares = 0;
   int en_count    = 0;

   // Walker model controls.
   logic [63:0] pte_cfg   = '0;
   int          k_cfg     = 20;
   int          stale_cfg = 0;
   int          wcnt      = 0;
   int          wphase    = 0;

   tlb_fill_ctrl #(
      .TLB_ENTRIES (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_vaddr   (req_vaddr),
      .resp_valid  (resp_valid),
      .resp_ack    (resp_ack),
      .resp_paddr  (resp_paddr),
      .resp_fault  (resp_fault),
      .flush       (flush),
      .walk_enable (walk_enable),
      .walk_vaddr  (walk_vaddr),
      .walk_ready  (walk_ready),
      .walk_pte    (walk_pte)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Walker: ready at rest; after enable optionally keeps a stale ready for stale_cfg cycles,
   // then drops ready for k_cfg cycles and returns with pte_cfg.
   always @(posedge clk) begin
      if (reset) begin
         walk_ready <= 1'b1;
         wphase     <= 0;
      end else if (walk_enable) begin
         if (stale_cfg > 0) begin
            wcnt   <= stale_cfg;
            wphase <= 1;
         end else begin
            walk_ready <= 1'b0;
            wcnt       <= k_cfg;
            wphase     <= 2;
         end
      end else if (wphase == 1) begin
         if (wcnt <= 1) begin
            walk_ready <= 1'b0;
            wcnt       <= k_cfg;
            wphase     <= 2;
         end else begin
            wcnt <= wcnt - 1;
         end
      end else if (wphase == 2) begin
         if (wcnt <= 1) begin
            walk_ready <= 1'b1;
            walk_pte   <= pte_cfg;
            wphase     <= 0;
         end else begin
            wcnt <= wcnt - 1;
         end
      end
   end

   always @(posedge clk) begin
      if (!reset && walk_enable) en_count <= en_count + 1;
   end

   // Duplicate-match monitor: at most one valid entry may match the address being looked up.
   int dup_m;
   always @(negedge clk) begin
      if (!reset && dut.state_q == StLookup) begin
         dup_m = 0;
         for (int i = 0; i < 8; i++) begin
            if (dut.u_cam.entries_q[i].valid && dut.u_cam.entries_q[i].vpn == walk_vaddr[47:12])
               dup_m++;
         end
         if (dup_m > 1) begin
            $display("FAIL dup_match: %0d entries match, required at most 1", dup_m);
            miscompares++;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
         miscompares++;
      end
   endtask

   task automatic do_req(input logic [63:0] va, input logic [63:0] pte, input bit exp_walk,
                         input logic [63:0] exp_pa, input bit exp_fault, input string nm);
      int en0;
      int lat;
      bit seen;
      pte_cfg = pte;
      @(negedge clk);
      chk({nm, " req_ready"}, 64'(req_ready), 64'd1);
      en0       = en_count;
      req_valid = 1'b1;
      req_vaddr = va;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat  = 1;
      seen = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (resp_valid) begin
            seen = 1'b1;
            break;
         end
         lat++;
      end
      if (!seen) begin
         $display("FAIL %s timeout: resp_valid not seen within 300 cycles", nm);
         vectors++;
         miscompares++;
      end
      chk({nm, " paddr"}, resp_paddr, exp_pa);
      chk({nm, " fault"}, 64'(resp_fault), 64'(exp_fault));
      chk({nm, " walks"}, 64'(en_count - en0), exp_walk ? 64'd1 : 64'd0);
      if (!exp_walk) chk({nm, " hit_latency"}, 64'(lat), 64'd2);
      @(negedge clk);
      chk({nm, " resp_held"}, 64'(resp_valid), 64'd1);
      resp_ack = 1'b1;
      @(posedge clk);
      #1 resp_ack = 1'b0;
   endtask

   typedef struct {
      logic [63:0] va;
      logic [63:0] pte;
      bit          walk;
      logic [63:0] pa;
      bit          fault;
   } vec_t;

   vec_t vt [5];

   initial begin
      bit got;
      vt[0] = '{64'h0000_1234_5678_9ABC, 64'h0000_0000_0ABC_D001, 1'b1, 64'h0000_0000_2AF3_4ABC, 1'b0};
      vt[1] = '{64'h0000_1234_5678_9FFF, 64'h0, 1'b0, 64'h0000_0000_2AF3_4FFF, 1'b0};
      vt[2] = '{64'h0000_0000_0000_5123, 64'h0, 1'b1, 64'h0, 1'b1};
      vt[3] = '{64'h0000_0000_0000_5123, 64'h0000_0000_0000_4401, 1'b1, 64'h0000_0000_0001_1123, 1'b0};
      vt[4] = '{64'h0000_0000_0000_5FFF, 64'h0, 1'b0, 64'h0000_0000_0001_1FFF, 1'b0};

      reset     = 1'b1;
      req_valid = 1'b0;
      req_vaddr = '0;
      resp_ack  = 1'b0;
      flush     = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("reset req_ready", 64'(req_ready), 64'd1);
      chk("reset resp_valid", 64'(resp_valid), 64'd0);
      chk("reset resp_fault", 64'(resp_fault), 64'd0);
      chk("reset resp_paddr", resp_paddr, 64'd0);
      chk("reset walk_enable", 64'(walk_enable), 64'd0);
      chk("reset walk_vaddr", walk_vaddr, 64'd0);

      // Cold miss, hit, fault (no fill), refill of the faulted page, hit.
      for (int i = 0; i < 5; i++) begin
         do_req(vt[i].va, vt[i].pte, vt[i].walk, vt[i].pa, vt[i].fault, $sformatf("vec%0d", i));
         if (i == 0) begin
            chk("cold entry0 valid", 64'(dut.u_cam.entries_q[0].valid), 64'd1);
            chk("cold entry0 vpn", 64'(dut.u_cam.entries_q[0].vpn), 64'h1_2345_6789);
         end
      end
      chk("victim after fault", 64'(dut.victim_q), 64'd2);

      // Flush while idle: previously cached page must miss.
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      do_req(vt[0].va, vt[0].pte, 1'b1, vt[0].pa, 1'b0, "post_flush");

      // Reset in the middle of a walk.
      k_cfg = 30;
      @(negedge clk);
      req_valid = 1'b1;
      req_vaddr = 64'h0000_0000_0042_0000;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("midwalk walk_vaddr", walk_vaddr, 64'h0000_0000_0042_0000);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("midwalk req_ready", 64'(req_ready), 64'd1);
      chk("midwalk resp_valid", 64'(resp_valid), 64'd0);

      // Nine distinct pages into eight entries: the ninth fill evicts the first.
      k_cfg = 3;
      for (int p = 0; p < 9; p++) begin
         do_req((64'(p + 1) << 12) | 64'h10, (64'(p + 'h100) << 10) | 64'h1, 1'b1,
                (64'(p + 'h100) << 12) | 64'h10, 1'b0, $sformatf("fill%0d", p));
      end
      chk("evict entry0 vpn", 64'(dut.u_cam.entries_q[0].vpn), 64'd9);
      do_req(64'h0000_0000_0000_9010, 64'h0, 1'b0, 64'h0000_0000_0010_8010, 1'b0, "page9_hit");
      do_req(64'h0000_0000_0000_3010, 64'h0, 1'b0, 64'h0000_0000_0010_2010, 1'b0, "page3_hit");
      do_req(64'h0000_0000_0000_1010, 64'h0000_0000_0004_0001, 1'b1,
             64'h0000_0000_0010_0010, 1'b0, "page1_miss");

      // Stale ready held for three cycles after enable; PTE must come from the real return.
      stale_cfg = 3;
      k_cfg     = 4;
      do_req(64'h0000_0000_7700_0ABC, 64'h0000_0000_1234_5401, 1'b1,
             64'h0000_0000_48D1_5ABC, 1'b0, "stale");
      stale_cfg = 0;

      // Flush during WALK_WAIT: translation still returned, but nothing is kept.
      k_cfg = 10;
      fork
         do_req(64'h0000_0000_ABCD_E123, 64'h0000_0000_0000_0C01, 1'b1,
                64'h0000_0000_0000_3123, 1'b0, "flush_walk");
         begin
            got = 1'b0;
            for (int c = 0; c < 100; c++) begin
               @(negedge clk);
               if (walk_enable) begin
                  got = 1'b1;
                  break;
               end
            end
            chk("flush_walk enable seen", 64'(got), 64'd1);
            repeat (4) @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
         end
      join
      k_cfg = 3;
      do_req(64'h0000_0000_ABCD_E123, 64'h0000_0000_0000_0C01, 1'b1,
             64'h0000_0000_0000_3123, 1'b0, "flush_walk_again");
      do_req(64'h0000_0000_7700_0ABC, 64'h0000_0000_1234_5401, 1'b1,
             64'h0000_0000_48D1_5ABC, 1'b0, "stale_page_flushed");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
